// File: rtl/complex_power_avg_pkg.sv
// Shared widths and defaults for the complex power averager.
package complex_power_avg_pkg;

  localparam int DEF_DW           = 16;
  localparam int DEF_QBITS        = 15;
  localparam int DEF_NCH          = 4;
  localparam int DEF_MAX_LOG2_AVG = 8;

  // Width of the squared magnitude after dropping QBITS fraction bits.
  function automatic int pw_f(input int dw, input int qbits);
    return 2 * dw - qbits;
  endfunction

  // Channel tag width; a single channel still gets one tag bit.
  function automatic int cw_f(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

  // Width of the averaging-window exponent input.
  function automatic int aw_f(input int max_log2_avg);
    return (max_log2_avg > 0) ? $clog2(max_log2_avg + 1) : 1;
  endfunction

  // Accumulator holds up to 2^MAX_LOG2_AVG full-scale powers.
  function automatic int accw_f(input int dw, input int qbits, input int max_log2_avg);
    return pw_f(dw, qbits) + max_log2_avg;
  endfunction

endpackage

// File: rtl/cplx_mag_sq.sv
// Two-stage |x|^2 with fraction truncation; valid and tag ride alongside.
module cplx_mag_sq
  import complex_power_avg_pkg::*;
#(
  parameter int DW    = DEF_DW,
  parameter int QBITS = DEF_QBITS,
  parameter int TAG_W = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic                          clr,
  input  logic                          sample_valid,
  input  logic signed [DW-1:0]          re,
  input  logic signed [DW-1:0]          im,
  input  logic [TAG_W-1:0]              tag,
  output logic                          p_valid,
  output logic [pw_f(DW, QBITS)-1:0]    p,
  output logic [TAG_W-1:0]              p_tag
);

  localparam int PW = pw_f(DW, QBITS);

  logic                 s1_valid;
  logic signed [DW-1:0] s1_re;
  logic signed [DW-1:0] s1_im;
  logic [TAG_W-1:0]     s1_tag;

  // Squares are non-negative, so the 2*DW-bit unsigned sum cannot wrap.
  logic signed [2*DW-1:0] sq_re;
  logic signed [2*DW-1:0] sq_im;
  logic [2*DW-1:0]        sq_sum;

  assign sq_re  = s1_re * s1_re;
  assign sq_im  = s1_im * s1_im;
  assign sq_sum = sq_re + sq_im;

  // Stage valids: cleared by reset or flush, otherwise advance with en.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      s1_valid <= 1'b0;
      p_valid  <= 1'b0;
    end else if (en) begin
      s1_valid <= sample_valid;
      p_valid  <= s1_valid;
    end
  end

  // Datapath registers need no reset; their valids qualify them.
  always_ff @(posedge clk) begin
    if (en) begin
      s1_re  <= re;
      s1_im  <= im;
      s1_tag <= tag;
      p      <= PW'(sq_sum >> QBITS);
      p_tag  <= s1_tag;
    end
  end

endmodule

// File: rtl/complex_power_avg.sv
// Per-channel block averager of complex sample power with output handshake.
module complex_power_avg
  import complex_power_avg_pkg::*;
#(
  parameter int DW           = DEF_DW,
  parameter int QBITS        = DEF_QBITS,
  parameter int NCH          = DEF_NCH,
  parameter int MAX_LOG2_AVG = DEF_MAX_LOG2_AVG
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic signed [DW-1:0]               data_i_re,
  input  logic signed [DW-1:0]               data_i_im,
  input  logic [cw_f(NCH)-1:0]               chan_i,
  input  logic                               valid_i,
  output logic                               ready_o,
  input  logic [aw_f(MAX_LOG2_AVG)-1:0]      avg_log2_i,
  input  logic                               clear_i,
  output logic [pw_f(DW, QBITS)-1:0]         power_o,
  output logic [cw_f(NCH)-1:0]               chan_o,
  output logic                               valid_o,
  input  logic                               ready_i
);

  localparam int PW   = pw_f(DW, QBITS);
  localparam int CW   = cw_f(NCH);
  localparam int AW   = aw_f(MAX_LOG2_AVG);
  localparam int ACCW = accw_f(DW, QBITS, MAX_LOG2_AVG);
  localparam int M    = MAX_LOG2_AVG;
  localparam logic [M-1:0] ONE_M = M'(1);

  logic          en;
  logic          chan_ok;
  logic          p_valid;
  logic [PW-1:0] p;
  logic [CW-1:0] p_tag;
  logic [AW-1:0] avg_log2_r;
  logic [M-1:0]  last_cnt;
  logic [ACCW-1:0] acc [NCH];
  logic [M-1:0]    cnt [NCH];
  logic [ACCW-1:0] acc_sum;
  logic            last_smp;

  // Whole pipeline moves only when the output slot can take a new result.
  assign en      = !valid_o || ready_i;
  assign ready_o = en;

  // Out-of-range channel tags are accepted but never enter the pipeline.
  if (NCH == (1 << CW)) begin : g_full_tag
    assign chan_ok = 1'b1;
  end else begin : g_part_tag
    assign chan_ok = (chan_i < CW'(NCH));
  end

  cplx_mag_sq #(
    .DW    (DW),
    .QBITS (QBITS),
    .TAG_W (CW)
  ) u_mag_sq (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .clr          (clear_i),
    .sample_valid (valid_i && en && chan_ok),
    .re           (data_i_re),
    .im           (data_i_im),
    .tag          (chan_i),
    .p_valid      (p_valid),
    .p            (p),
    .p_tag        (p_tag)
  );

  // Window exponent is captured only while in reset or flushing, clamped to the maximum.
  always_ff @(posedge clk) begin
    if (!rst_n || clear_i) begin
      avg_log2_r <= (avg_log2_i > AW'(MAX_LOG2_AVG)) ? AW'(MAX_LOG2_AVG) : avg_log2_i;
    end
  end

  // 2^avg - 1; at avg == M the shift wraps to zero and the subtract yields all ones.
  assign last_cnt = (ONE_M << avg_log2_r) - ONE_M;

  // Read side of the per-channel read-modify-write.
  always_comb begin
    acc_sum  = acc[p_tag] + ACCW'(p);
    last_smp = (cnt[p_tag] == last_cnt);
  end

  // Accumulate per channel; restart the channel once its window closes.
  always_ff @(posedge clk) begin
    if (!rst_n || clear_i) begin
      for (int i = 0; i < NCH; i++) begin
        acc[i] <= '0;
        cnt[i] <= '0;
      end
    end else if (en && p_valid) begin
      if (last_smp) begin
        acc[p_tag] <= '0;
        cnt[p_tag] <= '0;
      end else begin
        acc[p_tag] <= acc_sum;
        cnt[p_tag] <= cnt[p_tag] + ONE_M;
      end
    end
  end

  // Output slot: load a finished window, otherwise empty after a handshake.
  always_ff @(posedge clk) begin
    if (!rst_n || clear_i) begin
      valid_o <= 1'b0;
      power_o <= '0;
      chan_o  <= '0;
    end else if (en) begin
      if (p_valid && last_smp) begin
        valid_o <= 1'b1;
        power_o <= PW'(acc_sum >> avg_log2_r);
        chan_o  <= p_tag;
      end else begin
        valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_complex_power_avg.sv
// Directed-vector bench for complex_power_avg at default parameters.
module tb_complex_power_avg;

  logic               clk = 1'b0;
  logic               rst_n;
  logic signed [15:0] data_i_re;
  logic signed [15:0] data_i_im;
  logic [1:0]         chan_i;
  logic               valid_i;
  logic               ready_o;
  logic [3:0]         avg_log2_i;
  logic               clear_i;
  logic [16:0]        power_o;
  logic [1:0]         chan_o;
  logic               valid_o;
  logic               ready_i;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int last_acc;

  logic [16:0] q_pw [$];
  logic [1:0]  q_ch [$];
  int          q_cy [$];

  complex_power_avg dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_i_re  (data_i_re),
    .data_i_im  (data_i_im),
    .chan_i     (chan_i),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .avg_log2_i (avg_log2_i),
    .clear_i    (clear_i),
    .power_o    (power_o),
    .chan_o     (chan_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every output handshake, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && valid_o === 1'b1 && ready_i === 1'b1) begin
      q_pw.push_back(power_o);
      q_ch.push_back(chan_o);
      q_cy.push_back(cyc);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic flush_q();
    q_pw.delete();
    q_ch.delete();
    q_cy.delete();
  endtask

  // Present one sample and hold it until accepted; last_acc = cycle it was presented in.
  task automatic send(input logic signed [15:0] re, input logic signed [15:0] im,
                      input logic [1:0] ch);
    int guard;
    data_i_re = re;
    data_i_im = im;
    chan_i    = ch;
    valid_i   = 1'b1;
    guard     = 0;
    while (ready_o !== 1'b1 && guard < 50) begin
      step(1);
      guard++;
    end
    if (guard >= 50) begin
      n_cmp++;
      n_fail++;
      $display("FAIL send_timeout: ready_o stayed %b, required 1", ready_o);
    end
    last_acc = cyc;
    step(1);
    valid_i = 1'b0;
  endtask

  task automatic do_clear(input logic [3:0] avg);
    clear_i    = 1'b1;
    avg_log2_i = avg;
    step(1);
    clear_i    = 1'b0;
    step(1);
    flush_q();
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    valid_i    = 1'b0;
    ready_i    = 1'b1;
    clear_i    = 1'b0;
    avg_log2_i = 4'd2;
    data_i_re  = '0;
    data_i_im  = '0;
    chan_i     = '0;
    step(3);
    n_cmp++;
    if (valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid_o); end
    n_cmp++;
    if (power_o !== 17'h0) begin n_fail++; $display("FAIL reset_power: got %h want 0", power_o); end
    n_cmp++;
    if (chan_o !== 2'd0) begin n_fail++; $display("FAIL reset_chan: got %0d want 0", chan_o); end
    n_cmp++;
    if (ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready_during: got %b want 1", ready_o); end
    rst_n = 1'b1;
    step(1);
    n_cmp++;
    if (ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready_after: got %b want 1", ready_o); end
    n_cmp++;
    if (valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid_after: got %b want 0", valid_o); end
    flush_q();
  endtask

  // Window of 4 (latched at reset): four ch0 samples of 0x4000 average to 0x2000.
  task automatic test_window4();
    for (int i = 0; i < 4; i++) send(16'sh4000, 16'sh0000, 2'd0);
    step(8);
    n_cmp++;
    if (q_pw.size() != 1) begin
      n_fail++; $display("FAIL win4_count: got %0d outputs want 1", q_pw.size());
    end
    if (q_pw.size() >= 1) begin
      n_cmp++;
      if (q_pw[0] !== 17'h02000) begin n_fail++; $display("FAIL win4_power: got %h want 02000", q_pw[0]); end
      n_cmp++;
      if (q_ch[0] !== 2'd0) begin n_fail++; $display("FAIL win4_chan: got %0d want 0", q_ch[0]); end
      n_cmp++;
      if (q_cy[0] - last_acc != 3) begin
        n_fail++; $display("FAIL win4_latency: got %0d cycles want 3", q_cy[0] - last_acc);
      end
    end
    n_cmp++;
    if (valid_o !== 1'b0) begin n_fail++; $display("FAIL win4_valid_drop: got %b want 0", valid_o); end
  endtask

  // Unaveraged full-scale sample; also avg_log2_i changes outside clear must be ignored.
  task automatic test_max();
    do_clear(4'd0);
    avg_log2_i = 4'd3;
    send(-16'sh8000, -16'sh8000, 2'd2);
    send(16'sh4000, 16'sh0000, 2'd1);
    step(8);
    n_cmp++;
    if (q_pw.size() != 2) begin
      n_fail++; $display("FAIL max_count: got %0d outputs want 2", q_pw.size());
    end
    if (q_pw.size() >= 2) begin
      n_cmp++;
      if (q_pw[0] !== 17'h10000) begin n_fail++; $display("FAIL max_power: got %h want 10000", q_pw[0]); end
      n_cmp++;
      if (q_ch[0] !== 2'd2) begin n_fail++; $display("FAIL max_chan: got %0d want 2", q_ch[0]); end
      n_cmp++;
      if (q_pw[1] !== 17'h02000) begin n_fail++; $display("FAIL max_unlatched: got %h want 02000", q_pw[1]); end
    end
  endtask

  // Window of 2 over interleaved channels.
  task automatic test_interleave();
    logic [16:0] exp_pw [4];
    exp_pw[0] = 17'h00200;
    exp_pw[1] = 17'h00800;
    exp_pw[2] = 17'h01200;
    exp_pw[3] = 17'h02000;
    do_clear(4'd1);
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 4; c++)
        send(16'(16'h1000 * (c + 1)), 16'sh0000, 2'(c));
    step(8);
    n_cmp++;
    if (q_pw.size() != 4) begin
      n_fail++; $display("FAIL ilv_count: got %0d outputs want 4", q_pw.size());
    end
    for (int k = 0; k < 4 && k < q_pw.size(); k++) begin
      n_cmp++;
      if (q_pw[k] !== exp_pw[k] || q_ch[k] !== 2'(k)) begin
        n_fail++;
        $display("FAIL ilv_out%0d: got %h/ch%0d want %h/ch%0d", k, q_pw[k], q_ch[k], exp_pw[k], k);
      end
    end
  endtask

  // Downstream stall with a full pipeline and a waiting sample.
  task automatic test_stall();
    logic [16:0] exp_pw [4];
    logic [1:0]  exp_ch [4];
    exp_pw[0] = 17'h02000; exp_ch[0] = 2'd1;
    exp_pw[1] = 17'h00800; exp_ch[1] = 2'd2;
    exp_pw[2] = 17'h00200; exp_ch[2] = 2'd3;
    exp_pw[3] = 17'h01200; exp_ch[3] = 2'd0;
    do_clear(4'd0);
    ready_i = 1'b0;
    send(16'sh4000, 16'sh0000, 2'd1);
    send(16'sh2000, 16'sh0000, 2'd2);
    send(16'sh1000, 16'sh0000, 2'd3);
    data_i_re = 16'sh0000;
    data_i_im = 16'sh3000;
    chan_i    = 2'd0;
    valid_i   = 1'b1;
    for (int i = 0; i < 10; i++) begin
      n_cmp++;
      if (ready_o !== 1'b0 || valid_o !== 1'b1 || power_o !== 17'h02000 || chan_o !== 2'd1) begin
        n_fail++;
        $display("FAIL stall_hold%0d: got rdy=%b vld=%b pw=%h ch=%0d want 0/1/02000/1",
                 i, ready_o, valid_o, power_o, chan_o);
      end
      step(1);
    end
    ready_i = 1'b1;
    step(1);
    valid_i = 1'b0;
    step(8);
    n_cmp++;
    if (q_pw.size() != 4) begin
      n_fail++; $display("FAIL stall_count: got %0d outputs want 4", q_pw.size());
    end
    for (int k = 0; k < 4 && k < q_pw.size(); k++) begin
      n_cmp++;
      if (q_pw[k] !== exp_pw[k] || q_ch[k] !== exp_ch[k]) begin
        n_fail++;
        $display("FAIL stall_out%0d: got %h/ch%0d want %h/ch%0d", k, q_pw[k], q_ch[k], exp_pw[k], exp_ch[k]);
      end
    end
  endtask

  // Partial window flushed by clear_i (plus a sample in the clear cycle), then by a reset pulse.
  task automatic test_clear();
    do_clear(4'd2);
    for (int i = 0; i < 3; i++) send(16'sh2000, 16'sh0000, 2'd1);
    data_i_re  = 16'sh2000;
    data_i_im  = 16'sh0000;
    chan_i     = 2'd1;
    valid_i    = 1'b1;
    clear_i    = 1'b1;
    avg_log2_i = 4'd2;
    step(1);
    clear_i = 1'b0;
    valid_i = 1'b0;
    for (int i = 0; i < 4; i++) send(16'sh4000, 16'sh0000, 2'd1);
    step(8);
    n_cmp++;
    if (q_pw.size() != 1) begin
      n_fail++; $display("FAIL clear_count: got %0d outputs want 1", q_pw.size());
    end
    if (q_pw.size() >= 1) begin
      n_cmp++;
      if (q_pw[0] !== 17'h02000 || q_ch[0] !== 2'd1) begin
        n_fail++; $display("FAIL clear_out: got %h/ch%0d want 02000/ch1", q_pw[0], q_ch[0]);
      end
    end
    flush_q();
    send(16'sh2000, 16'sh0000, 2'd2);
    send(16'sh2000, 16'sh0000, 2'd2);
    rst_n      = 1'b0;
    avg_log2_i = 4'd2;
    step(1);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) send(16'sh4000, 16'sh0000, 2'd2);
    step(8);
    n_cmp++;
    if (q_pw.size() != 1) begin
      n_fail++; $display("FAIL rstmid_count: got %0d outputs want 1", q_pw.size());
    end
    if (q_pw.size() >= 1) begin
      n_cmp++;
      if (q_pw[0] !== 17'h02000 || q_ch[0] !== 2'd2) begin
        n_fail++; $display("FAIL rstmid_out: got %h/ch%0d want 02000/ch2", q_pw[0], q_ch[0]);
      end
    end
  endtask

  // Out-of-range exponent 15 clamps to 8: a 256-sample window.
  task automatic test_clamp();
    do_clear(4'd15);
    for (int i = 0; i < 255; i++) send(16'sh4000, 16'sh0000, 2'd3);
    step(6);
    n_cmp++;
    if (q_pw.size() != 0) begin
      n_fail++; $display("FAIL clamp_early: got %0d outputs want 0", q_pw.size());
    end
    send(16'sh4000, 16'sh0000, 2'd3);
    step(6);
    n_cmp++;
    if (q_pw.size() != 1) begin
      n_fail++; $display("FAIL clamp_count: got %0d outputs want 1", q_pw.size());
    end
    if (q_pw.size() >= 1) begin
      n_cmp++;
      if (q_pw[0] !== 17'h02000 || q_ch[0] !== 2'd3) begin
        n_fail++; $display("FAIL clamp_out: got %h/ch%0d want 02000/ch3", q_pw[0], q_ch[0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_window4();
    test_max();
    test_interleave();
    test_stall();
    test_clear();
    test_clamp();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/complex_power_avg.md
COMPLEX_POWER_AVG -- requirements
Module: complex_power_avg

Interface
REQ-001 SHALL have parameter DW, default 16, signed input component width.
REQ-002 SHALL have parameter QBITS, default 15, fractional bits removed after squaring.
REQ-003 SHALL have parameter NCH, default 4, number of time-interleaved channels; CW = max(1, clog2(NCH)).
REQ-004 SHALL have parameter MAX_LOG2_AVG, default 8, maximum log2 of averaging window; AW = clog2(MAX_LOG2_AVG+1).
REQ-005 SHALL have ports, clock and reset first:
  clk  in  1  single clock, rising edge;
  rst_n  in  1  synchronous, active-low reset;
  data_i_re  in  DW  signed real part;
  data_i_im  in  DW  signed imaginary part;
  chan_i  in  CW  channel tag of input sample;
  valid_i  in  1  input valid;
  ready_o  out  1  input ready;
  avg_log2_i  in  AW  window length = 2^avg_log2_i samples;
  clear_i  in  1  synchronous flush of pipeline, counters, accumulators;
  power_o  out  PW = 2*DW-QBITS  unsigned averaged power;
  chan_o  out  CW  channel tag of power_o;
  valid_o  out  1  output valid;
  ready_i  in  1  downstream ready.

Function
REQ-006 SHALL accept a sample when valid_i && ready_o; ready_o = !valid_o || ready_i (global enable en).
REQ-007 SHALL advance all pipeline stages only when en is high; stalled stages hold contents.
REQ-008 Stage 1 SHALL register re, im, chan and valid of accepted sample.
REQ-009 Stage 2 SHALL compute p = (re*re + im*im) >> QBITS, full 2*DW-bit unsigned sum, floor truncation, result PW bits, no overflow possible (max p = 2^(2*DW-1-QBITS) at re = im = -2^(DW-1)).
REQ-010 Stage 3 SHALL add p to acc[chan] (width PW+MAX_LOG2_AVG) and increment cnt[chan]; read-modify-write in one cycle, so back-to-back same-channel samples need no forwarding.
REQ-011 When cnt[chan] reaches 2^avg_log2_r - 1 before increment, stage 3 SHALL load power_o = (acc[chan]+p) >> avg_log2_r, chan_o = chan, valid_o = 1, and zero acc[chan], cnt[chan].
REQ-012 Latency SHALL be 3 cycles from acceptance of a window's last sample to valid_o, absent stalls.
REQ-013 valid_o, power_o, chan_o SHALL hold stable while valid_o && !ready_i.
REQ-014 valid_o SHALL drop the cycle after a handshake unless a new result loads in the same cycle.
REQ-015 avg_log2_r SHALL be latched from avg_log2_i only at reset release and on clear_i; values > MAX_LOG2_AVG clamp to MAX_LOG2_AVG.
REQ-016 avg_log2_r = 0 SHALL emit every sample unaveraged.
REQ-017 Samples with chan_i >= NCH SHALL be accepted and discarded (no accumulator update, no output).
REQ-018 clear_i SHALL, next cycle, zero all acc/cnt, invalidate stages 1-3, drop valid_o; a sample accepted in the clear_i cycle SHALL be discarded; clear_i overrides stall.
REQ-019 Channels SHALL be independent: interleaving order does not affect per-channel results.

Reset
REQ-020 While rst_n = 0 at a clk edge: valid_o = 0, power_o = 0, chan_o = 0, all stage valids = 0, acc/cnt = 0, avg_log2_r = clamp(avg_log2_i).
REQ-021 Reset mid-window or mid-stall SHALL discard all partial results; no output produced for pre-reset samples.
REQ-022 ready_o SHALL be 1 during and immediately after reset.

Structure
REQ-023 Shared package complex_power_avg_pkg SHALL hold width functions (PW, CW, AW, accumulator width) and default parameter constants.
REQ-024 Squaring stages 1-2 SHALL be sub-module cplx_mag_sq (DW, QBITS, TAG_W), with enable input and valid/tag passthrough.
REQ-025 Accumulators SHALL be NCH-entry register arrays, no RAM inference.

Verification
REQ-026 DW=16, QBITS=15, avg_log2_i=2: four ch0 samples re=0x4000, im=0, ready_i=1 -> single output power_o=0x2000, chan_o=0, 3 cycles after 4th accept.
REQ-027 avg_log2_i=0, re=im=-32768 -> power_o=0x10000 (17-bit max), no wrap.
REQ-028 Interleave ch0..ch3 with re=0x1000*(ch+1), im=0, window 2 -> outputs 0x0200, 0x0800, 0x1200, 0x2000 tagged 0..3 in order.
REQ-029 ready_i=0 for 10 cycles with output pending -> ready_o=0, power_o/chan_o stable, no samples lost; results resume in order after ready_i=1.
REQ-030 clear_i asserted after 3 of 4 ch1 samples, then 4 fresh samples re=0x4000 -> exactly one output 0x2000; rst_n pulse mid-window likewise yields no stale output.
